keypad_input_ctrl: RTL and testbench
====================================

Name: keypad_input_ctrl

Overview:
- Input-side responder for the processor's IN instruction.
- On request, collects a decimal number that the user keys in digit-by-digit from SW[3:0] and the pushbuttons.
- Returns the number through a valid/request handshake, and exposes the live entry value for the 7-segment display path.
- Sits between the board switches/keys and the CPU datapath, alongside the display output block.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive stable samples required before a key level is accepted (1 ms at 50 MHz).
- MAX_DIGITS, 8, maximum decimal digits accepted; matches the 8 HEX displays.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- input_req  input  1  CPU requests a value; held high until input_valid has been seen
- SW  input  18  board switches; SW[3:0] is the digit, SW[17] is the sign (optional feature only)
- key_digit_n  input  1  pushbutton, active-low, asynchronous: append digit
- key_confirm_n  input  1  pushbutton, active-low, asynchronous: confirm entry
- key_clear_n  input  1  pushbutton, active-low, asynchronous: clear entry
- input_data  output  32  confirmed value to the CPU
- input_valid  output  1  input_data is valid
- entry_value  output  32  current accumulator, for display
- digit_count  output  4  digits entered so far
- entering  output  1  high while in ENTRY state

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - input_data, entry_value = 0; digit_count = 0; input_valid = 0; entering = 0.
  - Debouncers go to the released state.
- Key path:
  - Each key passes a 2-FF synchronizer, then a counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it; any mismatch-free sample restarts the counter.
  - A press event is a single-cycle pulse on the debounced 1->0 transition; holding a key gives one event.
  - Latency from a raw edge to the event is DEBOUNCE_CYCLES+3 cycles.
- FSM states: IDLE, ENTRY, DONE.
  - IDLE: when input_req=1, go to ENTRY next cycle; clear entry_value and digit_count. Press events in IDLE are ignored.
  - ENTRY, per-cycle priority clear > confirm > digit:
    - clear event: entry_value = 0, digit_count = 0.
    - confirm event: input_data = entry_value; go to DONE.
    - digit event: if SW[3:0] <= 9 and digit_count < MAX_DIGITS, then entry_value = entry_value*10 + SW[3:0] and digit_count += 1. Otherwise the event is dropped with no change.
    - Arithmetic is 32-bit unsigned. With 8 digits the maximum is 99,999,999, so no overflow is possible.
    - input_req=0 in ENTRY: abort to IDLE; input_valid is never asserted.
  - DONE: input_valid=1 and input_data stable until input_req=0, then IDLE with input_valid=0 in the same transition.
    - input_req falling in the same cycle as entry to DONE: input_valid pulses one cycle, then IDLE.
- entering = (state==ENTRY). entry_value keeps its value in DONE and is cleared on the next request.
- Confirm with zero digits returns 0.

Optional Feature:
- Macro INPUT_SIGNED_EN.
- Defined:
  - SW[17] is sampled at the confirm event.
  - If SW[17]=1 and entry_value != 0, input_data = two's-complement negation of entry_value.
  - entry_value stays the unsigned magnitude.
- Undefined: SW[17] is ignored and input_data = entry_value.

Decomposition:
- Shared package io_pkg:
  - FSM state enum (IDLE, ENTRY, DONE).
  - BCD_MAX = 4'd9.
  - Default DEBOUNCE_CYCLES.
  - Data width constant 32.
- One sub-module, key_debounce: synchronizer, counter and press pulse, instantiated three times.

Test Plan (all scenarios with DEBOUNCE_CYCLES=4):
- Basic entry: req=1; digits 4, 2, 7 pressed with SW[3:0] set each time; confirm -> input_valid=1, input_data=427, digit_count=3; req=0 -> input_valid=0 next cycle, state IDLE.
- Bounce rejection: key_digit_n toggles every 2 cycles for 20 cycles, then stays low -> exactly one append; 3-cycle glitch -> no event.
- Limits:
  - SW[3:0]=12 plus digit press -> entry_value unchanged.
  - Nine presses of digit 9 -> entry_value=99999999, digit_count=8.
- Priority and clear: clear and digit presses debounce in the same cycle -> entry_value=0, digit_count=0. Clear then 5, confirm -> 5.
- Abort/reset:
  - req drops in ENTRY after digits 3, 1 -> no input_valid, IDLE; next req starts from 0.
  - reset asserted mid-ENTRY -> all outputs 0 immediately.
- INPUT_SIGNED_EN: entry 15 with SW[17]=1, confirm -> input_data=32'hFFFFFFF1. Entry 0 with sign -> 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and constants for the keypad input responder.
package io_pkg;

  localparam int          DATA_W       = 32;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [15:0] DEBOUNCE_DEF = 16'd50000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } io_state_e;

  typedef struct packed {
    logic clr;
    logic cfm;
    logic dig;
  } key_ev_t;

  function automatic logic [DATA_W-1:0] mul10_add(
    input logic [DATA_W-1:0] v,
    input logic [3:0]        d
  );
    return (v << 3) + (v << 1) + DATA_W'(d);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF sync, stability counter, press pulse.
module key_debounce
  import io_pkg::*;
#(
  parameter logic [15:0] CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic        s1_q, s2_q;
  logic        lvl_q, lvl_d;
  logic        prs_q, prs_d;
  logic [15:0] cnt_q, cnt_d;
  logic        run_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      lvl_q <= 1'b1;
      prs_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= key_n;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      cnt_q <= cnt_d;
    end
  end

  // this sample completes the run of differing samples
  assign run_full = ({1'b0, cnt_q} + 17'd1) >= {1'b0, CYCLES};

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    prs_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (run_full) begin
        lvl_d = s2_q;
        prs_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign press = prs_q;

endmodule

// File: rtl/keypad_input_ctrl.sv
// Decimal keypad entry for the IN instruction; sign switch under INPUT_SIGNED_EN.
module keypad_input_ctrl
  import io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int          MAX_DIGITS      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_req,
  input  logic [17:0]       SW,
  input  logic              key_digit_n,
  input  logic              key_confirm_n,
  input  logic              key_clear_n,
  output logic [DATA_W-1:0] input_data,
  output logic              input_valid,
  output logic [DATA_W-1:0] entry_value,
  output logic [3:0]        digit_count,
  output logic              entering
);

  io_state_e         st_q, st_d;
  key_ev_t           ev;
  logic              p_dig, p_cfm, p_clr;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] conf_val;
  logic              in_entry;
  logic              go_clr, go_cfm, go_dig;
  logic              dig_ok;
  logic              sw_unused;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dig (
    .clk   (clk),
    .reset (reset),
    .key_n (key_digit_n),
    .press (p_dig)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_cfm (
    .clk   (clk),
    .reset (reset),
    .key_n (key_confirm_n),
    .press (p_cfm)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk),
    .reset (reset),
    .key_n (key_clear_n),
    .press (p_clr)
  );

  assign ev = '{clr: p_clr, cfm: p_cfm, dig: p_dig};
  assign sw_unused = ^SW[17:4];

`ifdef INPUT_SIGNED_EN
  assign conf_val = (SW[17] && (acc_q != '0)) ? (~acc_q + 1'b1) : acc_q;
`else
  assign conf_val = acc_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      data_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (input_req) st_d = ENTRY;
      end
      ENTRY: begin
        if (!input_req) st_d = IDLE;
        else if (ev.clr) st_d = ENTRY;
        else if (ev.cfm) st_d = DONE;
      end
      DONE: begin
        if (!input_req) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // a request drop in ENTRY outranks any key event
  assign in_entry = (st_q == ENTRY) && input_req;
  assign dig_ok   = (SW[3:0] <= BCD_MAX)
                 && (int'(cnt_q) < MAX_DIGITS);
  assign go_clr   = ((st_q == IDLE) && input_req)
                 || (in_entry && ev.clr);
  assign go_cfm   = in_entry && !ev.clr && ev.cfm;
  assign go_dig   = in_entry && !ev.clr && !ev.cfm
                 && ev.dig && dig_ok;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    unique case (1'b1)
      go_clr: begin
        acc_d = '0;
        cnt_d = '0;
      end
      go_cfm: begin
        data_d = conf_val;
      end
      go_dig: begin
        acc_d = mul10_add(acc_q, SW[3:0]);
        cnt_d = cnt_q + 4'd1;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_comb begin
    input_valid = (st_q == DONE);
    entering    = (st_q == ENTRY);
    input_data  = data_q;
    entry_value = acc_q;
    digit_count = cnt_q;
  end

endmodule

// File: tb/tb_keypad_input_ctrl.sv
// Bench for keypad_input_ctrl: window-based key model plus directed entries.
module tb_keypad_input_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        input_req = 1'b0;
  logic [17:0] SW = '0;
  logic        key_digit_n = 1'b1;
  logic        key_confirm_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [31:0] input_data;
  logic [31:0] entry_value;
  logic        input_valid;
  logic        entering;
  logic [3:0]  digit_count;

  int passed = 0;
  int total  = 0;
  bit live   = 1'b0;

  always #5 clk = ~clk;

  keypad_input_ctrl #(
    .DEBOUNCE_CYCLES(16'(D)),
    .MAX_DIGITS     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_req    (input_req),
    .SW           (SW),
    .key_digit_n  (key_digit_n),
    .key_confirm_n(key_confirm_n),
    .key_clear_n  (key_clear_n),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .entry_value  (entry_value),
    .digit_count  (digit_count),
    .entering     (entering)
  );

  // Model: a key level flips once the last D samples seen past the
  // two-stage sync all disagree with it; the resulting press acts on
  // the following clock.
  int              m_st;
  longint unsigned m_acc;
  int              m_cnt;
  logic [31:0]     m_data;
  logic [2:0]      pend;
  logic [2:0]      lvl;
  logic [D+1:0]    hist [3];
  logic [2:0]      raw;
  logic            all_diff;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = 0;
      m_acc = 0;
      m_cnt = 0;
      m_data = '0;
      pend = '0;
      lvl = '1;
      for (int i = 0; i < 3; i++) hist[i] = '1;
    end else begin
      case (m_st)
        0: if (input_req) begin
          m_st = 1;
          m_acc = 0;
          m_cnt = 0;
        end
        1: if (!input_req) m_st = 0;
        else if (pend[2]) begin
          m_acc = 0;
          m_cnt = 0;
        end else if (pend[1]) begin
`ifdef INPUT_SIGNED_EN
          if (SW[17] && m_acc != 0) m_data = 32'(64'd0 - m_acc);
          else m_data = 32'(m_acc);
`else
          m_data = 32'(m_acc);
`endif
          m_st = 2;
        end else if (pend[0] && SW[3:0] <= 4'd9 && m_cnt < 8) begin
          m_acc = m_acc * 10 + SW[3:0];
          m_cnt = m_cnt + 1;
        end
        2: if (!input_req) m_st = 0;
        default: m_st = 0;
      endcase
      raw = {key_clear_n, key_confirm_n, key_digit_n};
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][D:0], raw[i]};
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (hist[i][j] == lvl[i]) all_diff = 1'b0;
        pend[i] = all_diff & lvl[i];
        if (all_diff) lvl[i] = ~lvl[i];
      end
    end
  end

  always @(negedge clk) begin
    if (live && reset) begin
      total++;
      if (input_valid === (m_st == 2) && entering === (m_st == 1)
          && digit_count === 4'(m_cnt)
          && entry_value === 32'(m_acc) && input_data === m_data)
        passed++;
      else
        $display("FAIL model t=%0t: valid %b/%b entering %b/%b cnt %0d/%0d entry %0d/%0d data %0h/%0h",
                 $time, input_valid, (m_st == 2), entering, (m_st == 1),
                 digit_count, m_cnt, entry_value, m_acc, input_data, m_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)",
                  name, act, act, exp, exp);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_digit_n = v;
      1: key_confirm_n = v;
      default: key_clear_n = v;
    endcase
  endtask

  task automatic press(input int k, input int hold = 12, input int gap = 12);
    set_key(k, 1'b0);
    repeat (hold) @(negedge clk);
    set_key(k, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] v);
    SW[3:0] = v;
    press(0);
  endtask

  task automatic request;
    input_req = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drop;
    input_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int vcnt;
  logic [31:0] exp_neg;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    live = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(input_valid), 32'd0);
    chk("reset_entering", 32'(entering), 32'd0);
    chk("reset_data", input_data, 32'd0);
    chk("reset_entry", entry_value, 32'd0);
    chk("reset_count", 32'(digit_count), 32'd0);

    // press while idle is ignored
    digit(4'd7);
    chk("idle_press", entry_value, 32'd0);

    request;
    chk("entering", 32'(entering), 32'd1);
    digit(4'd4);
    digit(4'd2);
    digit(4'd7);
    press(1);
    chk("basic_valid", 32'(input_valid), 32'd1);
    chk("basic_data", input_data, 32'd427);
    chk("basic_count", 32'(digit_count), 32'd3);
    input_req = 1'b0;
    @(negedge clk);
    chk("basic_drop_valid", 32'(input_valid), 32'd0);
    chk("basic_drop_entering", 32'(entering), 32'd0);
    @(negedge clk);

    request;
    SW[3:0] = 4'd6;
    for (int i = 0; i < 10; i++) begin
      key_digit_n = ~key_digit_n;
      repeat (2) @(negedge clk);
    end
    key_digit_n = 1'b0;
    repeat (15) @(negedge clk);
    key_digit_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("bounce_entry", entry_value, 32'd6);
    chk("bounce_count", 32'(digit_count), 32'd1);
    press(0, 3, 15);
    chk("glitch_entry", entry_value, 32'd6);

    digit(4'd12);
    chk("bad_digit", entry_value, 32'd6);
    press(2);
    chk("clear_entry", entry_value, 32'd0);
    for (int i = 0; i < 9; i++) digit(4'd9);
    chk("max_entry", entry_value, 32'd99999999);
    chk("max_count", 32'(digit_count), 32'd8);

    SW[3:0] = 4'd3;
    key_clear_n = 1'b0;
    key_digit_n = 1'b0;
    repeat (12) @(negedge clk);
    key_clear_n = 1'b1;
    key_digit_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("prio_entry", entry_value, 32'd0);
    chk("prio_count", 32'(digit_count), 32'd0);
    digit(4'd5);
    press(1);
    chk("prio_data", input_data, 32'd5);
    chk("prio_valid", 32'(input_valid), 32'd1);
    drop;

    request;
    digit(4'd3);
    digit(4'd1);
    chk("abort_entry", entry_value, 32'd31);
    input_req = 1'b0;
    @(negedge clk);
    chk("abort_entering", 32'(entering), 32'd0);
    chk("abort_valid", 32'(input_valid), 32'd0);
    repeat (3) @(negedge clk);
    request;
    chk("rereq_entry", entry_value, 32'd0);
    chk("rereq_count", 32'(digit_count), 32'd0);
    press(1);
    chk("zero_valid", 32'(input_valid), 32'd1);
    chk("zero_data", input_data, 32'd0);
    drop;

    // req drops right as DONE is entered: one-cycle valid
    request;
    digit(4'd2);
    vcnt = 0;
    key_confirm_n = 1'b0;
    for (int i = 0; i < D + 3; i++) begin
      @(negedge clk);
      if (input_valid) vcnt++;
    end
    input_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (input_valid) vcnt++;
    end
    key_confirm_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("pulse_cycles", 32'(vcnt), 32'd1);
    chk("pulse_data", input_data, 32'd2);

    request;
    digit(4'd8);
    chk("pre_reset_entry", entry_value, 32'd8);
    #2 reset = 1'b0;
    input_req = 1'b0;
    #1;
    chk("async_reset", {input_data[15:0], entry_value[13:0], entering, input_valid}
                       | {28'd0, digit_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef INPUT_SIGNED_EN
    exp_neg = 32'hFFFFFFF1;
`else
    exp_neg = 32'd15;
`endif
    request;
    digit(4'd1);
    digit(4'd5);
    SW[17] = 1'b1;
    press(1);
    chk("sign_data", input_data, exp_neg);
    chk("sign_entry", entry_value, 32'd15);
    drop;
    request;
    press(1);
    chk("sign_zero", input_data, 32'd0);
    drop;
    SW = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
